// File: rtl/iir_pkg.sv
// Shared defaults and width helper for the decimating IIR back end.
package iir_pkg;

    localparam int W_DEF     = 14;
    localparam int LOG2R_DEF = 2;
    localparam int DEPTH_DEF = 4;

    // Accumulator width: R samples of W+1 bits need LOG2R extra bits to never wrap.
    function automatic int acc_w(input int w, input int log2r);
        return w + 1 + log2r;
    endfunction

    localparam int ACC_W_DEF = W_DEF + 1 + LOG2R_DEF;

endpackage

// File: rtl/iir_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// The head entry is visible on dout whenever the FIFO is not empty; dout is 0 when empty.
module iir_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // A pop on empty is ignored; a push on full is only taken if a pop frees the slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    // Next pointer and storage values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers mask stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/iir_decim.sv
// Decimate-by-R (R = 2^LOG2R) block: sums R valid samples, scales by 1/R and
// queues the result in an FWFT output FIFO. Results arriving at a full FIFO
// with no pop are dropped and latch the sticky ovf_out flag.
// Optional build macro IIR_DECIM_ROUND_EN: round-half-up instead of truncation.
module iir_decim
    import iir_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOG2R = LOG2R_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W:0]   x_in,
    input  logic         en_in,
    output logic [W:0]   y_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         ovf_out
);

    localparam int AW = acc_w(W, LOG2R);

`ifdef IIR_DECIM_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2R - 1);
`endif

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;
    logic [LOG2R-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 dump;
    logic                 drop;
    logic [W:0]           result;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Divide the group sum by R; the sum of R samples divided by R always fits W+1 bits.
    function automatic logic [W:0] scale(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] t;
`ifdef IIR_DECIM_ROUND_EN
        t = s + HALF;
`else
        t = s;
`endif
        return (W+1)'(t >>> LOG2R);
    endfunction

    assign x_ext  = {{LOG2R{x_in[W]}}, x_in};
    assign sum    = acc_q + x_ext;
    assign dump   = en_in && (&cnt_q);
    assign result = scale(sum);
    // Full implies non-empty, so ready_in alone decides whether a slot frees up.
    assign drop   = dump && fifo_full && !ready_in;

    // Accumulate on every valid sample; the last sample of a group restarts the sum.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | drop;
        if (en_in) begin
            cnt_d = cnt_q + LOG2R'(1);
            acc_d = dump ? '0 : sum;
        end
    end

    // State registers; reset wins over en_in and ready_in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    iir_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (dump),
        .din     (result),
        .pop     (ready_in),
        .dout    (y_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign valid_out = !fifo_empty;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_iir_decim.sv
// Self-checking bench for iir_decim (W=14, LOG2R=2, DEPTH=4).
module tb_iir_decim;

    localparam int R    = 4;
    localparam int FDEP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] x_in = '0;
    logic        en_in = 1'b0;
    logic [14:0] y_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        ovf_out;

    logic signed [14:0] y_s;
    assign y_s = y_out;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: group of samples, output queue, sticky drop flag
    int grp_sum = 0;
    int grp_cnt = 0;
    int q[$];
    bit m_ovf = 1'b0;

    iir_decim dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x_in      (x_in),
        .en_in     (en_in),
        .y_out     (y_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    // mean of a group of R samples: floor(sum/R), or floor((sum+R/2)/R) when rounding
    function automatic int group_result(input int s);
        int v;
        int d;
        v = s;
`ifdef IIR_DECIM_ROUND_EN
        v = v + R / 2;
`endif
        d = v / R;
        if ((v % R) != 0 && v < 0) d = d - 1;
        return d;
    endfunction

    function automatic logic [16:0] exp_vec();
        int h;
        logic [31:0] hv;
        h  = (q.size() > 0) ? q[0] : 0;
        hv = h;
        return {q.size() > 0, hv[14:0], m_ovf};
    endfunction

    function automatic logic [16:0] got_vec();
        return {valid_out, y_out, ovf_out};
    endfunction

    // advance the model by one clock edge with the given inputs
    task automatic model_edge(input bit rst, input bit en, input int x, input bit rdy);
        if (rst) begin
            grp_sum = 0;
            grp_cnt = 0;
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (en) begin
                grp_sum += x;
                grp_cnt++;
                if (grp_cnt == R) begin
                    if (q.size() < FDEP) q.push_back(group_result(grp_sum));
                    else m_ovf = 1'b1;
                    grp_sum = 0;
                    grp_cnt = 0;
                end
            end
        end
    endtask

    // drive one cycle of inputs, step the model, then sample 1 time unit after the edge
    task automatic cycle(input bit rst, input bit en, input int x, input bit rdy);
        logic [31:0] xv;
        xv       = x;
        reset_n  = !rst;
        en_in    = en;
        x_in     = xv[14:0];
        ready_in = rdy;
        model_edge(rst, en, x, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1234, 1);
        cycle(1, 0, 0, 0);
        n_cmp++;
        if (got_vec() !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_state: got {valid,y,ovf}=%h want 0", got_vec());
        end
    endtask

    task automatic test_basic();
        int s[4] = '{100, 200, 300, 400};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, s[i], 1);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL basic_cycle%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (valid_out !== 1'b1 || y_s !== 15'sd250) begin
            n_bad++;
            $display("FAIL basic_250: got valid=%b y=%0d want valid=1 y=250", valid_out, y_s);
        end
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (valid_out !== 1'b0 || y_out !== 15'd0) begin
            n_bad++;
            $display("FAIL basic_one_cycle: got valid=%b y=%0d want valid=0 y=0", valid_out, y_s);
        end
    endtask

    task automatic test_rounding();
        int seqs[3][4] = '{'{1, 1, 1, 0}, '{-1, -1, 0, 0}, '{-1, -1, -1, -1}};
`ifdef IIR_DECIM_ROUND_EN
        int want[3] = '{1, 0, -1};
`else
        int want[3] = '{0, -1, -1};
`endif
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) cycle(0, 1, seqs[g][i], 1);
            n_cmp++;
            if (valid_out !== 1'b1 || int'(y_s) != want[g]) begin
                n_bad++;
                $display("FAIL round_seq%0d: got valid=%b y=%0d want valid=1 y=%0d", g, valid_out, y_s, want[g]);
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL round_model%0d: got %h want %h", g, got_vec(), exp_vec());
            end
        end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 16383, 0);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ovf_fill%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (ovf_out !== 1'b1 || valid_out !== 1'b1 || y_s !== 15'sd16383) begin
            n_bad++;
            $display("FAIL ovf_full: got ovf=%b valid=%b y=%0d want 1 1 16383", ovf_out, valid_out, y_s);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            n_cmp++;
            if (valid_out !== (i < 3) || ovf_out !== 1'b1 || got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (ovf_out !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: got ovf=%b want 1", ovf_out);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 1);
        n_cmp++;
        if (ovf_out !== 1'b0 || valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_clear: got ovf=%b valid=%b want 0 0", ovf_out, valid_out);
        end
        cycle(0, 1, 500, 1);
        cycle(0, 1, 500, 1);
        cycle(1, 1, 500, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8, 0);
        n_cmp++;
        if (valid_out !== 1'b1 || y_s !== 15'sd8) begin
            n_bad++;
            $display("FAIL rst_mid: got valid=%b y=%0d want valid=1 y=8", valid_out, y_s);
        end
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (valid_out !== 1'b0 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rst_single: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 48; i++) begin
            cycle(0, (i % 3) == 0, int'($urandom_range(0, 32767)) - 16384, 1);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL gapped%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1, int'($urandom_range(0, 32767)) - 16384, ($urandom_range(0, 3) != 0));
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 60; i++) begin
            cycle(0, $urandom_range(0, 1), int'($urandom_range(0, 32767)) - 16384, $urandom_range(0, 1));
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mixed%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_reset_mid();
        test_gapped();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
